// File: rtl/axis_fft_frame_adapter.sv
// AXI4-Stream adapter in front of a fixed-latency, non-stallable FFT core.
// Credit-throttled input, output FIFO, regenerated output tlast and tlast-misalignment flag.
module axis_fft_frame_adapter #(
    parameter int DATA_W    = 16,
    parameter int N_POINTS  = 128,
    parameter int CORE_LAT  = 140,
    parameter int OUT_DEPTH = 256
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [2*DATA_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [2*DATA_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [2*DATA_W/8-1:0] m_axis_tkeep,
    output logic                  core_start,
    output logic                  core_valid,
    output logic [DATA_W-1:0]     core_in_re,
    output logic [DATA_W-1:0]     core_in_im,
    input  logic                  core_out_valid,
    input  logic [DATA_W-1:0]     core_out_re,
    input  logic [DATA_W-1:0]     core_out_im,
    output logic                  frame_err,
    input  logic                  clr_err
);
    localparam int TD_W  = 2 * DATA_W;
    localparam int IDX_W = $clog2(N_POINTS);
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int FC_W  = AW + 1;
    localparam int IF_W  = $clog2(CORE_LAT + OUT_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    logic                 ready_en_q;
    logic [FC_W-1:0]      fifo_count_q, fifo_count_d;
    logic [IF_W-1:0]      in_flight_q, in_flight_d;
    logic [IDX_W-1:0]     in_idx_q, in_idx_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic                 core_valid_q, core_start_q;
    logic [DATA_W-1:0]    core_re_q, core_im_q;
    logic                 frame_err_q, frame_err_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [TD_W-1:0]      mem_q [OUT_DEPTH];

    logic [IF_W:0]        credit_used;
    logic                 in_accept, fifo_full, fifo_empty;
    logic                 rd_en, wr_en, overflow, tlast_err;

    // Credits cover both samples inside the core and samples already queued, so the
    // core can never present a result the FIFO has no room for.
    assign credit_used   = {1'b0, in_flight_q} + (IF_W+1)'(fifo_count_q);
    assign s_axis_tready = ready_en_q && (credit_used < (IF_W+1)'(OUT_DEPTH));
    assign in_accept     = s_axis_tvalid && s_axis_tready;

    assign fifo_full  = (fifo_count_q == FC_W'(OUT_DEPTH));
    assign fifo_empty = (fifo_count_q == '0);
    assign rd_en      = m_axis_tready && !fifo_empty;
    assign wr_en      = core_out_valid && (!fifo_full || rd_en);
    assign overflow   = core_out_valid && fifo_full && !rd_en;

    always_comb begin
        in_idx_d  = in_idx_q;
        tlast_err = 1'b0;
        if (in_accept) begin
            if (s_axis_tlast && (in_idx_q != LAST_IDX)) begin
                tlast_err = 1'b1;
                in_idx_d  = '0;
            end else begin
                tlast_err = !s_axis_tlast && (in_idx_q == LAST_IDX);
                in_idx_d  = in_idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        in_flight_d = in_flight_q;
        case ({in_accept, core_out_valid})
            2'b10:   in_flight_d = in_flight_q + IF_W'(1);
            2'b01:   in_flight_d = (in_flight_q != '0) ? in_flight_q - IF_W'(1) : in_flight_q;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        case ({wr_en, rd_en})
            2'b10:   fifo_count_d = fifo_count_q + FC_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - FC_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // A new error wins over a simultaneous clear.
    assign frame_err_d = tlast_err || overflow || (frame_err_q && !clr_err);
    assign out_idx_d   = rd_en ? out_idx_q + IDX_W'(1) : out_idx_q;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            ready_en_q   <= 1'b0;
            fifo_count_q <= '0;
            in_flight_q  <= '0;
            in_idx_q     <= '0;
            out_idx_q    <= '0;
            core_valid_q <= 1'b0;
            core_start_q <= 1'b0;
            core_re_q    <= '0;
            core_im_q    <= '0;
            frame_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            ready_en_q   <= 1'b1;
            fifo_count_q <= fifo_count_d;
            in_flight_q  <= in_flight_d;
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            core_valid_q <= in_accept;
            core_start_q <= in_accept && (in_idx_q == '0);
            frame_err_q  <= frame_err_d;
            if (in_accept) begin
                core_re_q <= s_axis_tdata[TD_W-1:DATA_W];
                core_im_q <= s_axis_tdata[DATA_W-1:0];
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {core_out_re, core_out_im};
    end

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && (out_idx_q == LAST_IDX);
    assign m_axis_tkeep  = '1;
    assign core_valid    = core_valid_q;
    assign core_start    = core_start_q;
    assign core_in_re    = core_re_q;
    assign core_in_im    = core_im_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_axis_fft_frame_adapter.sv
// Bench for axis_fft_frame_adapter: identity core model with a CORE_LAT delay line,
// frame-table vectors, hand sequences for backpressure, resync and reset.
module tb_axis_fft_frame_adapter;
    localparam int DW = 16;
    localparam int TDW = 2 * DW;
    localparam int NP = 128;
    localparam int CORE_LAT = 140;
    localparam int OUT_DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n;
    logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [TDW-1:0] s_axis_tdata;
    logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [TDW-1:0] m_axis_tdata;
    logic [TDW/8-1:0] m_axis_tkeep;
    logic core_start, core_valid, core_out_valid;
    logic [DW-1:0] core_in_re, core_in_im, core_out_re, core_out_im;
    logic frame_err, clr_err;

    axis_fft_frame_adapter #(.DATA_W(DW), .N_POINTS(NP), .CORE_LAT(CORE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep),
        .core_start(core_start), .core_valid(core_valid),
        .core_in_re(core_in_re), .core_in_im(core_in_im),
        .core_out_valid(core_out_valid), .core_out_re(core_out_re), .core_out_im(core_out_im),
        .frame_err(frame_err), .clr_err(clr_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // identity FFT core stand-in: sample in on core_valid, out CORE_LAT cycles later
    logic [TDW:0] pipe [CORE_LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORE_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {core_valid, core_in_re, core_in_im};
            for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign core_out_valid = pipe[CORE_LAT-1][TDW];
    assign core_out_re    = pipe[CORE_LAT-1][TDW-1:DW];
    assign core_out_im    = pipe[CORE_LAT-1][DW-1:0];

    // scoreboard
    logic [TDW-1:0] exp_q[$];
    int n_vec = 0, n_fail = 0;
    int acc_cnt = 0, start_cnt = 0, out_cnt = 0, exp_out_idx = 0, seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && s_axis_tvalid && s_axis_tready) begin
            exp_q.push_back(s_axis_tdata);
            acc_cnt++;
        end
        if (rst_n && core_start) start_cnt++;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("out_unexpected", 64'd1, 64'd0);
            else check("out_data", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
            check("out_tlast", 64'(m_axis_tlast), 64'(exp_out_idx == NP - 1));
            exp_out_idx = (exp_out_idx + 1) % NP;
            out_cnt++;
        end
    end

    // driver tasks
    function automatic logic [TDW-1:0] mk(input int k);
        logic [DW-1:0] a, b;
        a = DW'(k * 37 + 5);
        b = DW'(k) ^ 16'hA5C3;
        return {a, b};
    endfunction

    task automatic send_beat(input logic [TDW-1:0] d, input logic last);
        int budget;
        budget = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (!s_axis_tready && budget < 5000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 5000) check("s_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_n(input int n, input int tlast_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            send_beat(mk(seq), (tlast_at >= 0) && ((i % NP) == tlast_at));
            seq++;
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 3000) check("drain_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        int n;
        int tlast_at;
        bit clr_first;
        bit exp_err;
        int exp_starts;
    } vec_t;

    vec_t tbl[7];
    bit rnd_stop;
    int lat;

    initial begin
        // frame table; in_idx carries over from one record to the next
        tbl[0] = '{128, 127, 1'b0, 1'b0, 1};  // clean frame
        tbl[1] = '{128,  63, 1'b1, 1'b1, 2};  // early tlast: resync, second start at beat 64
        tbl[2] = '{ 64,  63, 1'b1, 1'b0, 0};  // finishes the resynced frame cleanly
        tbl[3] = '{128,  -1, 1'b1, 1'b1, 1};  // missing tlast on the last beat
        tbl[4] = '{256, 127, 1'b1, 1'b0, 2};  // two clean frames
        tbl[5] = '{ 10,   9, 1'b1, 1'b1, 1};  // runt frame
        tbl[6] = '{128, 127, 1'b1, 1'b0, 1};  // clean frame after runt

        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_core_valid", 64'(core_valid), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("tkeep", 64'(m_axis_tkeep), 64'hF);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_rst", 64'(s_axis_tready), 64'd1);

        // first frame, measuring empty-pipe latency on beat 0
        start_cnt = 0; out_cnt = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk(seq); s_axis_tlast = 1'b0; seq++;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        lat = 1;
        while (!m_axis_tvalid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(CORE_LAT + 2));
        send_n(NP - 1, NP - 2, 1'b0);
        wait_drain();
        check("f1_out_cnt", 64'(out_cnt), 64'(NP));
        check("f1_starts", 64'(start_cnt), 64'd1);
        check("f1_err", 64'(frame_err), 64'd0);

        // table-driven frame vectors
        for (int v = 0; v < 7; v++) begin
            if (tbl[v].clr_first) pulse_clr();
            start_cnt = 0;
            send_n(tbl[v].n, tbl[v].tlast_at, 1'b0);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_err", v), 64'(frame_err), 64'(tbl[v].exp_err));
            check($sformatf("tbl%0d_starts", v), 64'(start_cnt), 64'(tbl[v].exp_starts));
        end
        wait_drain();

        // early tlast on beat 63: error next cycle, next beat restarts the frame
        pulse_clr();
        send_n(63, -1, 1'b0);
        check("pre63_err", 64'(frame_err), 64'd0);
        send_beat(mk(seq), 1'b1); seq++;
        check("err_next_cycle", 64'(frame_err), 64'd1);
        check("beat63_no_start", 64'(core_start), 64'd0);
        send_beat(mk(seq), 1'b0); seq++;
        check("resync_start", 64'(core_start), 64'd1);
        // clear coinciding with a new error keeps the flag
        check("clr_collide_ready", 64'(s_axis_tready), 64'd1);
        s_axis_tvalid = 1'b1; s_axis_tdata = mk(seq); s_axis_tlast = 1'b1; clr_err = 1'b1; seq++;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; clr_err = 1'b0;
        check("clr_vs_err", 64'(frame_err), 64'd1);
        pulse_clr();
        check("clr_err", 64'(frame_err), 64'd0);
        wait_drain();

        // three frames against a stalled sink: credits stop input at OUT_DEPTH
        m_axis_tready = 1'b0; acc_cnt = 0; out_cnt = 0;
        fork
            send_n(3 * NP, NP - 1, 1'b0);
            begin
                for (int b = 0; b < 1500 && acc_cnt < OUT_DEPTH; b++) begin
                    @(posedge clk); #1;
                end
                repeat (300) @(posedge clk);
                #1;
                check("bp_accepted", 64'(acc_cnt), 64'(OUT_DEPTH));
                check("bp_s_tready", 64'(s_axis_tready), 64'd0);
                check("bp_m_tvalid", 64'(m_axis_tvalid), 64'd1);
                m_axis_tready = 1'b1;
            end
        join
        wait_drain();
        check("bp_out_cnt", 64'(out_cnt), 64'(3 * NP));
        check("bp_err", 64'(frame_err), 64'd0);

        // reset at beat 40 with results already queued
        m_axis_tready = 1'b0;
        send_n(40, -1, 1'b0);
        repeat (CORE_LAT + 5) @(posedge clk);
        #1;
        check("pre_rst_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_s_tready", 64'(s_axis_tready), 64'd0);
        check("mrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mrst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("mrst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("mrst_core_valid", 64'(core_valid), 64'd0);
        check("mrst_core_start", 64'(core_start), 64'd0);
        exp_q.delete();
        exp_out_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_empty", 64'(m_axis_tvalid), 64'd0);
        send_beat(mk(seq), 1'b0); seq++;
        check("post_rst_start", 64'(core_start), 64'd1);
        send_n(NP - 1, NP - 2, 1'b0);
        wait_drain();
        check("post_rst_err", 64'(frame_err), 64'd0);

        // random valid/ready over ten frames
        out_cnt = 0; rnd_stop = 1'b0;
        fork
            begin
                send_n(10 * NP, NP - 1, 1'b1);
                rnd_stop = 1'b1;
            end
            begin
                while (!rnd_stop) begin
                    @(posedge clk); #1;
                    m_axis_tready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain();
        check("rnd_out_cnt", 64'(out_cnt), 64'(10 * NP));
        check("rnd_err", 64'(frame_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
